// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle control unit: opcodes, FSM state encoding, ALU op codes.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_ADDI = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_ANDI = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_ORI  = 4'b0111;
  localparam logic [3:0] OP_LW   = 4'b1000;
  localparam logic [3:0] OP_SW   = 4'b1001;
  localparam logic [3:0] OP_BEQ  = 4'b1010;
  localparam logic [3:0] OP_JMP  = 4'b1011;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [1:0] PC_SRC_INC    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // Values are visible on the estado debug port, so the encoding is fixed.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  function automatic logic is_legal(input logic [3:0] op);
    return (op <= OP_JMP) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/decodificador_ula.sv
// Combinational opcode decode to ALU operation and ALU B-operand select.
import cpu_pkg::*;

module decodificador_ula (
  input  logic [3:0] opcode,
  output logic [1:0] alu_op,
  output logic       alu_src
);

  always_comb begin
    alu_op  = ALU_ADD;
    alu_src = 1'b0;
    case (opcode)
      OP_ADD:  alu_op = ALU_ADD;
      OP_ADDI: begin alu_op = ALU_ADD; alu_src = 1'b1; end
      OP_SUB:  alu_op = ALU_SUB;
      OP_AND:  alu_op = ALU_AND;
      OP_ANDI: begin alu_op = ALU_AND; alu_src = 1'b1; end
      OP_OR:   alu_op = ALU_OR;
      OP_ORI:  begin alu_op = ALU_OR;  alu_src = 1'b1; end
      OP_LW:   begin alu_op = ALU_ADD; alu_src = 1'b1; end
      OP_SW:   begin alu_op = ALU_ADD; alu_src = 1'b1; end
      OP_BEQ:  alu_op = ALU_SUB;
      default: ;
    endcase
  end

endmodule

// File: rtl/unidade_controle.sv
// Multicycle CPU control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT/TRAP).
// Define UNIDADE_CONTROLE_TRAP_EN to trap illegal opcodes and expose the illegal port.
import cpu_pkg::*;

module unidade_controle (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       alu_src,
  output logic [1:0] Controle_ALUop,
  output logic       reg_we,
  output logic       wb_sel,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
`ifdef UNIDADE_CONTROLE_TRAP_EN
  output logic       illegal,
`endif
  output logic       halted,
  output logic [2:0] estado
);

  state_t     state_reg, state_next;
  logic [1:0] dec_alu_op;
  logic       dec_alu_src;

  decodificador_ula u_decodificador_ula (
    .opcode  (opcode),
    .alu_op  (dec_alu_op),
    .alu_src (dec_alu_src)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= ST_FETCH;
    else       state_reg <= state_next;
  end

  assign estado = state_reg;

  always_comb begin
    state_next     = state_reg;
    ir_we          = 1'b0;
    pc_we          = 1'b0;
    pc_src         = PC_SRC_INC;
    alu_src        = 1'b0;
    Controle_ALUop = ALU_ADD;
    reg_we         = 1'b0;
    wb_sel         = 1'b0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    iord           = 1'b0;
    halted         = 1'b0;
`ifdef UNIDADE_CONTROLE_TRAP_EN
    illegal        = 1'b0;
`endif

    // ALU controls only matter while an instruction is in flight.
    if (state_reg == ST_EXEC || state_reg == ST_MEM || state_reg == ST_WB) begin
      Controle_ALUop = dec_alu_op;
      alu_src        = dec_alu_src;
    end

    case (state_reg)
      ST_FETCH: begin
        mem_req = 1'b1;
        // Strobes are held off while reset is asserted so reset values stay clean.
        if (mem_ready && !reset) begin
          ir_we      = 1'b1;
          pc_we      = 1'b1;
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (opcode)
          OP_NOP:  state_next = ST_FETCH;
          OP_HALT: state_next = ST_HALT;
          OP_JMP: begin
            pc_we      = 1'b1;
            pc_src     = PC_SRC_JUMP;
            state_next = ST_FETCH;
          end
          default: begin
            if (is_legal(opcode)) state_next = ST_EXEC;
`ifdef UNIDADE_CONTROLE_TRAP_EN
            else                  state_next = ST_TRAP;
`else
            else                  state_next = ST_FETCH;
`endif
          end
        endcase
      end
      ST_EXEC: begin
        if (opcode == OP_LW || opcode == OP_SW) begin
          state_next = ST_MEM;
        end else if (opcode == OP_BEQ) begin
          if (zero) begin
            pc_we  = 1'b1;
            pc_src = PC_SRC_BRANCH;
          end
          state_next = ST_FETCH;
        end else begin
          state_next = ST_WB;
        end
      end
      ST_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (opcode == OP_SW);
        if (mem_ready) state_next = (opcode == OP_LW) ? ST_WB : ST_FETCH;
      end
      ST_WB: begin
        reg_we     = 1'b1;
        wb_sel     = (opcode == OP_LW);
        state_next = ST_FETCH;
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      ST_TRAP: begin
`ifdef UNIDADE_CONTROLE_TRAP_EN
        illegal = 1'b1;
`else
        state_next = ST_FETCH;
`endif
      end
      default: state_next = ST_FETCH;
    endcase
  end

endmodule

// File: tb/tb_unidade_controle.sv
// Directed-vector bench for unidade_controle; expected values are hand-derived per instruction flow.
module tb_unidade_controle;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       ir_we, pc_we, alu_src, reg_we, wb_sel, mem_req, mem_we, iord, halted;
  logic [1:0] pc_src, Controle_ALUop;
  logic [2:0] estado;
`ifdef UNIDADE_CONTROLE_TRAP_EN
  logic       illegal;
`endif

  int vectors = 0;
  int miscompares = 0;

  unidade_controle dut (
    .clk            (clk),
    .reset          (reset),
    .opcode         (opcode),
    .zero           (zero),
    .mem_ready      (mem_ready),
    .ir_we          (ir_we),
    .pc_we          (pc_we),
    .pc_src         (pc_src),
    .alu_src        (alu_src),
    .Controle_ALUop (Controle_ALUop),
    .reg_we         (reg_we),
    .wb_sel         (wb_sel),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .iord           (iord),
`ifdef UNIDADE_CONTROLE_TRAP_EN
    .illegal        (illegal),
`endif
    .halted         (halted),
    .estado         (estado)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; outputs are examined 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Complete a zero-wait fetch of op; returns with the FSM in DECODE.
  task automatic fetch(input logic [3:0] op);
    opcode    = op;
    mem_ready = 1'b1;
    #1;
    chk("fetch_state", estado, 0);
    chk("fetch_ir_we", ir_we, 1);
    chk("fetch_pc_we", pc_we, 1);
    chk("fetch_pc_src", pc_src, 0);
    tick();
    mem_ready = 1'b0;
    #1;
    chk("decode_state", estado, 1);
  endtask

  // Single-cycle ALU op from DECODE: EXEC then WB then FETCH.
  task automatic alu_op_check(input logic [3:0] op, input logic [1:0] exp_op, input logic exp_src);
    fetch(op);
    tick();
    chk("alu_exec_state", estado, 2);
    chk("alu_exec_aluop", Controle_ALUop, exp_op);
    chk("alu_exec_alusrc", alu_src, exp_src);
    tick();
    chk("alu_wb_state", estado, 4);
    chk("alu_wb_reg_we", reg_we, 1);
    chk("alu_wb_aluop", Controle_ALUop, exp_op);
    tick();
    chk("alu_back_fetch", estado, 0);
  endtask

  initial begin
    reset = 1'b1; opcode = 4'b0000; zero = 1'b0; mem_ready = 1'b1;
    #3;
    // Reset values, with mem_ready high to confirm no strobe leaks
    chk("rst_estado", estado, 0);
    chk("rst_mem_req", mem_req, 1);
    chk("rst_iord", iord, 0);
    chk("rst_ir_we", ir_we, 0);
    chk("rst_pc_we", pc_we, 0);
    chk("rst_reg_we", reg_we, 0);
    chk("rst_halted", halted, 0);
    chk("rst_aluop", Controle_ALUop, 0);
    chk("rst_alu_src", alu_src, 0);
    mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // ADDI with two wait cycles in FETCH
    opcode = 4'b0010;
    tick();
    chk("addi_wait1_state", estado, 0);
    chk("addi_wait1_ir_we", ir_we, 0);
    chk("addi_wait1_mem_req", mem_req, 1);
    tick();
    chk("addi_wait2_state", estado, 0);
    chk("addi_wait2_pc_we", pc_we, 0);
    tick();
    mem_ready = 1'b1; #1;
    chk("addi_fetch3_ir_we", ir_we, 1);
    chk("addi_fetch3_pc_we", pc_we, 1);
    tick();
    mem_ready = 1'b0;
    chk("addi_decode", estado, 1);
    chk("addi_decode_aluop", Controle_ALUop, 0);
    tick();
    chk("addi_exec", estado, 2);
    chk("addi_exec_aluop", Controle_ALUop, 0);
    chk("addi_exec_alusrc", alu_src, 1);
    chk("addi_exec_reg_we", reg_we, 0);
    tick();
    chk("addi_wb", estado, 4);
    chk("addi_wb_reg_we", reg_we, 1);
    chk("addi_wb_sel", wb_sel, 0);
    tick();
    chk("addi_done", estado, 0);

    // Other ALU encodings
    alu_op_check(4'b0011, 2'b01, 1'b0);
    alu_op_check(4'b0100, 2'b10, 1'b0);
    alu_op_check(4'b0111, 2'b11, 1'b1);
    alu_op_check(4'b0110, 2'b11, 1'b0);

    // BEQ taken, then not taken
    fetch(4'b1010);
    tick();
    zero = 1'b1; #1;
    chk("beq_t_state", estado, 2);
    chk("beq_t_pc_we", pc_we, 1);
    chk("beq_t_pc_src", pc_src, 1);
    chk("beq_t_aluop", Controle_ALUop, 1);
    tick();
    zero = 1'b0;
    chk("beq_t_back", estado, 0);
    fetch(4'b1010);
    tick();
    chk("beq_nt_state", estado, 2);
    chk("beq_nt_pc_we", pc_we, 0);
    tick();
    chk("beq_nt_back", estado, 0);

    // LW zero-wait: mem_ready raised during EXEC is ignored there
    fetch(4'b1000);
    tick();
    mem_ready = 1'b1; #1;
    chk("lw_exec_state", estado, 2);
    chk("lw_exec_mem_req", mem_req, 0);
    tick();
    chk("lw_mem_state", estado, 3);
    chk("lw_mem_iord", iord, 1);
    chk("lw_mem_we", mem_we, 0);
    chk("lw_mem_req", mem_req, 1);
    tick();
    mem_ready = 1'b0;
    chk("lw_wb_state", estado, 4);
    chk("lw_wb_sel", wb_sel, 1);
    chk("lw_wb_reg_we", reg_we, 1);
    tick();
    chk("lw_back", estado, 0);

    // SW zero-wait
    fetch(4'b1001);
    tick();
    mem_ready = 1'b1; #1;
    tick();
    chk("sw_mem_state", estado, 3);
    chk("sw_mem_we", mem_we, 1);
    chk("sw_mem_iord", iord, 1);
    chk("sw_mem_reg_we", reg_we, 0);
    tick();
    mem_ready = 1'b0; #1;
    chk("sw_back", estado, 0);
    chk("sw_back_reg_we", reg_we, 0);

    // JMP and NOP resolve in DECODE
    fetch(4'b1011);
    chk("jmp_pc_we", pc_we, 1);
    chk("jmp_pc_src", pc_src, 2);
    tick();
    chk("jmp_back", estado, 0);
    fetch(4'b0000);
    chk("nop_pc_we", pc_we, 0);
    tick();
    chk("nop_back", estado, 0);

    // Reset during a MEM wait
    fetch(4'b1000);
    tick();
    tick();
    chk("rmem_state", estado, 3);
    #2 reset = 1'b1;
    #1;
    chk("rmem_estado", estado, 0);
    chk("rmem_reg_we", reg_we, 0);
    chk("rmem_iord", iord, 0);
    tick();
    chk("rmem_held", estado, 0);
    chk("rmem_held_reg_we", reg_we, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("rmem_resume_state", estado, 0);
    chk("rmem_resume_req", mem_req, 1);
    chk("rmem_resume_reg_we", reg_we, 0);

    // Illegal opcode 1100
    fetch(4'b1100);
    tick();
`ifdef UNIDADE_CONTROLE_TRAP_EN
    chk("illegal_state", estado, 6);
    chk("illegal_flag", illegal, 1);
    mem_ready = 1'b1;
    tick();
    chk("trap_absorb", estado, 6);
    chk("trap_ir_we", ir_we, 0);
    chk("trap_mem_req", mem_req, 0);
    mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("trap_reset_state", estado, 0);
`else
    chk("illegal_nop", estado, 0);
    chk("illegal_reg_we", reg_we, 0);
`endif

    // HALT absorbs for 20 cycles regardless of mem_ready
    fetch(4'b1111);
    tick();
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0]; #1;
      chk("halt_state", estado, 5);
      chk("halt_flag", halted, 1);
      chk("halt_mem_req", mem_req, 0);
      chk("halt_ir_we", ir_we, 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
